id_ex_stage: RTL and testbench
==============================

ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 Parameter: BITS, default 32, datapath width of operands, immediates and PC.
REQ-002 Port: clk  input  1  rising-edge clock.
REQ-003 Port: rst  input  1  asynchronous, active-high reset.
REQ-004 Port: stall  input  1  hold the EX stage contents (hazard unit).
REQ-005 Port: flush  input  1  insert bubble into EX (branch/jump redirect).
REQ-006 Port: id_valid  input  1  ID holds a valid instruction.
REQ-007 Port: id_pc, id_rs1_data, id_rs2_data, id_imm  input  BITS each  decode-stage values.
REQ-008 Port: id_rs1_addr, id_rs2_addr, id_rd_addr  input  5 each  register indices.
REQ-009 Port: id_alu_op  input  4  ALU operation encoding (alu_t).
REQ-010 Port: id_a_sel, id_b_sel  input  1 each  A: 0=rs1, 1=PC; B: 0=rs2, 1=imm.
REQ-011 Port: id_reg_write, id_mem_read  input  1 each  writeback enable, load instruction.
REQ-012 Port: mem_rd_addr, wb_rd_addr  input  5 each; mem_reg_write, wb_reg_write  input  1 each; mem_result, wb_result  input  BITS each  forwarding sources.
REQ-013 Port: ex_A, ex_B  output  BITS each  ALU operands.
REQ-014 Port: ex_alu_op  output  4; ex_shamt  output  5  (= ex_B[4:0]).
REQ-015 Port: ex_store_data, ex_pc  output  BITS each  forwarded rs2, registered PC.
REQ-016 Port: ex_valid, ex_reg_write, ex_mem_read  output  1 each; ex_rd_addr  output  5.
REQ-017 Port: load_use_stall  output  1  combinational load-use hazard request.

Function
REQ-018 Registered state updates on rising clk only; priority rst > flush > stall > load.
REQ-019 Load (no stall, no flush): capture all id_* fields; ex_valid <= id_valid; ex_reg_write/ex_mem_read <= id value AND id_valid.
REQ-020 Flush: ex_valid, ex_reg_write, ex_mem_read, ex_rd_addr, ex_alu_op <= 0; flush during stall still flushes.
REQ-021 Stall: control fields, PC, imm, addresses held; rs1/rs2 operand registers reload with their forwarded values each stalled cycle, so a result retiring from MEM/WB during the stall is not lost.
REQ-022 Forwarding per operand (rs1, rs2): registered addr == 0 -> 0; else MEM match (mem_reg_write, mem_rd_addr == addr) -> mem_result; else WB match -> wb_result; else registered data; MEM has priority over WB.
REQ-023 ex_A = id_a_sel(reg) ? ex_pc : fwd_rs1; ex_B = b_sel(reg) ? imm : fwd_rs2; ex_store_data = fwd_rs2 regardless of b_sel.
REQ-024 Forwarding and output muxing combinational from registered state and current MEM/WB inputs; zero-cycle latency to ALU.
REQ-025 load_use_stall = ex_valid & ex_mem_read & (ex_rd_addr != 0) & (ex_rd_addr == id_rs1_addr | ex_rd_addr == id_rs2_addr) & id_valid.
REQ-026 Instruction latency ID->EX: exactly one clk when not stalled.

Reset
REQ-027 rst asserted: immediately (no clk) all registered state to 0; ex_valid=0, ex_reg_write=0, ex_mem_read=0, ex_alu_op=0000 (ADD), ex_A=ex_B=ex_pc=0, load_use_stall=0.
REQ-028 rst deasserted: first rising clk performs a normal load.
REQ-029 rst mid-stall or mid-flush: reset wins; held instruction discarded.

Verification
REQ-030 Plain load: id_rs1_data=5, id_imm=7, b_sel=1, alu_op=0000, valid -> next cycle ex_A=5, ex_B=7, ex_valid=1.
REQ-031 Double forward: ex rs1=x3; mem_rd=3 result 0xAA, wb_rd=3 result 0xBB, both write -> ex_A=0xAA; mem_reg_write=0 -> ex_A=0xBB.
REQ-032 x0 guard: rs1=x0, mem_rd=0, mem_reg_write=1, mem_result=0xFFFF_FFFF -> ex_A=0.
REQ-033 Stall capture: stall 2 cycles, WB writes x5=0x1234 in cycle 1 only, ex rs2=x5 -> after release ex_B=0x1234.
REQ-034 Load-use: EX holds lw x7 (valid), ID reads rs2=x7 -> load_use_stall=1; ex_rd_addr=0 -> 0.
REQ-035 Flush+stall same cycle -> next cycle ex_valid=0, ex_reg_write=0; async rst mid-cycle -> outputs 0 before next clk.

Source files
------------

// File: rtl/id_ex_stage.sv
// ---------------------------------------------------------------------------
// id_ex_stage
// ID/EX pipeline register with operand forwarding and load-use detection.
//
// The EX stage keeps the decoded instruction in registers. The ALU operands
// are built combinationally from that registered state and the current
// MEM/WB results, so a forwarded value reaches the ALU in the same cycle.
//
// Ports
//   clk, rst           rising-edge clock, asynchronous active-high reset
//   stall, flush       hold EX contents / insert a bubble (flush wins)
//   id_*               decode-stage instruction fields
//   mem_*, wb_*        forwarding sources from the MEM and WB stages
//   ex_A, ex_B         ALU operands (after forwarding and a/b select)
//   ex_alu_op,ex_shamt ALU operation and shift amount (ex_B[4:0])
//   ex_store_data      forwarded rs2 value, used by stores
//   ex_pc              registered PC
//   ex_valid, ex_reg_write, ex_mem_read, ex_rd_addr  EX control fields
//   load_use_stall     combinational load-use hazard request
// ---------------------------------------------------------------------------
module id_ex_stage #(
   parameter int BITS = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            stall,
   input  logic            flush,
   input  logic            id_valid,
   input  logic [BITS-1:0] id_pc,
   input  logic [BITS-1:0] id_rs1_data,
   input  logic [BITS-1:0] id_rs2_data,
   input  logic [BITS-1:0] id_imm,
   input  logic [4:0]      id_rs1_addr,
   input  logic [4:0]      id_rs2_addr,
   input  logic [4:0]      id_rd_addr,
   input  logic [3:0]      id_alu_op,
   input  logic            id_a_sel,
   input  logic            id_b_sel,
   input  logic            id_reg_write,
   input  logic            id_mem_read,
   input  logic [4:0]      mem_rd_addr,
   input  logic [4:0]      wb_rd_addr,
   input  logic            mem_reg_write,
   input  logic            wb_reg_write,
   input  logic [BITS-1:0] mem_result,
   input  logic [BITS-1:0] wb_result,
   output logic [BITS-1:0] ex_A,
   output logic [BITS-1:0] ex_B,
   output logic [3:0]      ex_alu_op,
   output logic [4:0]      ex_shamt,
   output logic [BITS-1:0] ex_store_data,
   output logic [BITS-1:0] ex_pc,
   output logic            ex_valid,
   output logic            ex_reg_write,
   output logic            ex_mem_read,
   output logic [4:0]      ex_rd_addr,
   output logic            load_use_stall
);

   // ALU encoding 0000 is ADD; bubbles carry this harmless operation.
   localparam logic [3:0] ALU_ADD = 4'b0000;

   // Control state
   logic            valid_r;
   logic            reg_write_r;
   logic            mem_read_r;
   logic [4:0]      rd_addr_r;
   logic [3:0]      alu_op_r;
   // Datapath state
   logic            a_sel_r;
   logic            b_sel_r;
   logic [BITS-1:0] pc_r;
   logic [BITS-1:0] imm_r;
   logic [4:0]      rs1_addr_r;
   logic [4:0]      rs2_addr_r;
   logic [BITS-1:0] rs1_data_r;
   logic [BITS-1:0] rs2_data_r;
   // Forwarded operands
   logic [BITS-1:0] fwd_rs1_s;
   logic [BITS-1:0] fwd_rs2_s;

   // Operand bypass: x0 is always zero; the younger MEM result beats WB.
   function automatic logic [BITS-1:0] fwd_value(
      input logic [4:0]      addr,
      input logic [BITS-1:0] reg_data,
      input logic            m_we,
      input logic [4:0]      m_rd,
      input logic [BITS-1:0] m_res,
      input logic            w_we,
      input logic [4:0]      w_rd,
      input logic [BITS-1:0] w_res
   );
      logic [BITS-1:0] val;
      if (addr == 5'd0) begin
         val = '0;
      end else if (m_we && (m_rd == addr)) begin
         val = m_res;
      end else if (w_we && (w_rd == addr)) begin
         val = w_res;
      end else begin
         val = reg_data;
      end
      return val;
   endfunction

   // Forwarding network for both register operands.
   always_comb begin
      fwd_rs1_s = fwd_value(rs1_addr_r, rs1_data_r, mem_reg_write, mem_rd_addr,
                            mem_result, wb_reg_write, wb_rd_addr, wb_result);
      fwd_rs2_s = fwd_value(rs2_addr_r, rs2_data_r, mem_reg_write, mem_rd_addr,
                            mem_result, wb_reg_write, wb_rd_addr, wb_result);
   end

   // Control register: reset > flush (bubble) > stall (hold) > load.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_r     <= 1'b0;
         reg_write_r <= 1'b0;
         mem_read_r  <= 1'b0;
         rd_addr_r   <= 5'd0;
         alu_op_r    <= ALU_ADD;
      end else if (flush) begin
         valid_r     <= 1'b0;
         reg_write_r <= 1'b0;
         mem_read_r  <= 1'b0;
         rd_addr_r   <= 5'd0;
         alu_op_r    <= ALU_ADD;
      end else if (!stall) begin
         valid_r     <= id_valid;
         reg_write_r <= id_reg_write & id_valid;
         mem_read_r  <= id_mem_read & id_valid;
         rd_addr_r   <= id_rd_addr;
         alu_op_r    <= id_alu_op;
      end
   end

   // Datapath register. While stalled the operand registers soak up the
   // forwarded values so a result retiring from MEM/WB is not lost.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_sel_r    <= 1'b0;
         b_sel_r    <= 1'b0;
         pc_r       <= '0;
         imm_r      <= '0;
         rs1_addr_r <= 5'd0;
         rs2_addr_r <= 5'd0;
         rs1_data_r <= '0;
         rs2_data_r <= '0;
      end else if (flush) begin
         // Bubble: control is cleared, datapath contents are don't-care.
         a_sel_r    <= a_sel_r;
      end else if (stall) begin
         rs1_data_r <= fwd_rs1_s;
         rs2_data_r <= fwd_rs2_s;
      end else begin
         a_sel_r    <= id_a_sel;
         b_sel_r    <= id_b_sel;
         pc_r       <= id_pc;
         imm_r      <= id_imm;
         rs1_addr_r <= id_rs1_addr;
         rs2_addr_r <= id_rs2_addr;
         rs1_data_r <= id_rs1_data;
         rs2_data_r <= id_rs2_data;
      end
   end

   // Operand selection and output drive.
   always_comb begin
      ex_A          = a_sel_r ? pc_r : fwd_rs1_s;
      ex_B          = b_sel_r ? imm_r : fwd_rs2_s;
      ex_shamt      = ex_B[4:0];
      ex_store_data = fwd_rs2_s;
      ex_pc         = pc_r;
      ex_alu_op     = alu_op_r;
      ex_valid      = valid_r;
      ex_reg_write  = reg_write_r;
      ex_mem_read   = mem_read_r;
      ex_rd_addr    = rd_addr_r;
   end

   // Load-use hazard: a valid load in EX whose destination is read by ID.
   always_comb begin
      load_use_stall = valid_r & mem_read_r & (rd_addr_r != 5'd0) &
                       ((rd_addr_r == id_rs1_addr) | (rd_addr_r == id_rs2_addr)) &
                       id_valid;
   end

endmodule

// File: tb/tb_id_ex_stage.sv
// ---------------------------------------------------------------------------
// tb_id_ex_stage
// Directed checks of the documented scenarios, then a randomized run
// compared against a behavioural model of the EX-stage instruction record.
// ---------------------------------------------------------------------------
module tb_id_ex_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall, flush, id_valid;
   logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
   logic [4:0]  id_rs1_addr, id_rs2_addr, id_rd_addr;
   logic [3:0]  id_alu_op;
   logic        id_a_sel, id_b_sel, id_reg_write, id_mem_read;
   logic [4:0]  mem_rd_addr, wb_rd_addr;
   logic        mem_reg_write, wb_reg_write;
   logic [31:0] mem_result, wb_result;
   logic [31:0] ex_A, ex_B, ex_store_data, ex_pc;
   logic [3:0]  ex_alu_op;
   logic [4:0]  ex_shamt, ex_rd_addr;
   logic        ex_valid, ex_reg_write, ex_mem_read, load_use_stall;

   int n_checks = 0;
   int n_fail   = 0;

   id_ex_stage #(.BITS(32)) dut (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush), .id_valid(id_valid),
      .id_pc(id_pc), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
      .id_imm(id_imm), .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
      .id_rd_addr(id_rd_addr), .id_alu_op(id_alu_op), .id_a_sel(id_a_sel),
      .id_b_sel(id_b_sel), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
      .mem_rd_addr(mem_rd_addr), .wb_rd_addr(wb_rd_addr),
      .mem_reg_write(mem_reg_write), .wb_reg_write(wb_reg_write),
      .mem_result(mem_result), .wb_result(wb_result),
      .ex_A(ex_A), .ex_B(ex_B), .ex_alu_op(ex_alu_op), .ex_shamt(ex_shamt),
      .ex_store_data(ex_store_data), .ex_pc(ex_pc), .ex_valid(ex_valid),
      .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
      .ex_rd_addr(ex_rd_addr), .load_use_stall(load_use_stall)
   );

   // Free-running clock, 10 time units per cycle.
   always #5 clk = ~clk;

   // Single comparison point for every check in the bench.
   task automatic check_val(input string tag, input logic [31:0] obs,
                            input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic clear_inputs();
      stall = 1'b0; flush = 1'b0; id_valid = 1'b0;
      id_pc = 32'd0; id_rs1_data = 32'd0; id_rs2_data = 32'd0; id_imm = 32'd0;
      id_rs1_addr = 5'd0; id_rs2_addr = 5'd0; id_rd_addr = 5'd0;
      id_alu_op = 4'd0; id_a_sel = 1'b0; id_b_sel = 1'b0;
      id_reg_write = 1'b0; id_mem_read = 1'b0;
      mem_rd_addr = 5'd0; wb_rd_addr = 5'd0;
      mem_reg_write = 1'b0; wb_reg_write = 1'b0;
      mem_result = 32'd0; wb_result = 32'd0;
   endtask

   // Advance one clock; leave time just past the edge for driving/checking.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // ---------------- behavioural model of the instruction held in EX -------
   typedef struct {
      logic        valid, rw, mr, asel, bsel;
      logic [4:0]  rd, rs1, rs2;
      logic [3:0]  op;
      logic [31:0] pc, imm, d1, d2;
   } ex_rec_t;

   ex_rec_t m;

   function automatic ex_rec_t empty_rec();
      ex_rec_t r;
      r.valid = 1'b0; r.rw = 1'b0; r.mr = 1'b0; r.asel = 1'b0; r.bsel = 1'b0;
      r.rd = 5'd0; r.rs1 = 5'd0; r.rs2 = 5'd0; r.op = 4'd0;
      r.pc = 32'd0; r.imm = 32'd0; r.d1 = 32'd0; r.d2 = 32'd0;
      return r;
   endfunction

   // Architectural value of register 'a' as seen by EX right now:
   // newest pending write (MEM, then WB), else the value read in ID.
   function automatic logic [31:0] arch_value(input logic [4:0] a,
                                              input logic [31:0] read_val);
      logic [31:0] v;
      v = read_val;
      if (wb_reg_write && wb_rd_addr == a)   v = wb_result;
      if (mem_reg_write && mem_rd_addr == a) v = mem_result;
      if (a == 5'd0)                         v = 32'd0;
      return v;
   endfunction

   task automatic model_clock();
      logic [31:0] v1, v2;
      v1 = arch_value(m.rs1, m.d1);
      v2 = arch_value(m.rs2, m.d2);
      if (rst) begin
         m = empty_rec();
      end else if (flush) begin
         m.valid = 1'b0; m.rw = 1'b0; m.mr = 1'b0; m.rd = 5'd0; m.op = 4'd0;
      end else if (stall) begin
         m.d1 = v1; m.d2 = v2;
      end else begin
         m.valid = id_valid; m.rw = id_reg_write && id_valid;
         m.mr = id_mem_read && id_valid; m.rd = id_rd_addr; m.op = id_alu_op;
         m.asel = id_a_sel; m.bsel = id_b_sel; m.pc = id_pc; m.imm = id_imm;
         m.rs1 = id_rs1_addr; m.rs2 = id_rs2_addr;
         m.d1 = id_rs1_data; m.d2 = id_rs2_data;
      end
   endtask

   task automatic check_model();
      logic [31:0] a_exp, b_exp, s_exp;
      logic        lu;
      a_exp = m.asel ? m.pc  : arch_value(m.rs1, m.d1);
      b_exp = m.bsel ? m.imm : arch_value(m.rs2, m.d2);
      s_exp = arch_value(m.rs2, m.d2);
      lu = m.valid && m.mr && m.rd != 5'd0 && id_valid &&
           (m.rd == id_rs1_addr || m.rd == id_rs2_addr);
      check_val("rnd_A",     ex_A, a_exp);
      check_val("rnd_B",     ex_B, b_exp);
      check_val("rnd_shamt", {27'd0, ex_shamt}, {27'd0, b_exp[4:0]});
      check_val("rnd_store", ex_store_data, s_exp);
      check_val("rnd_pc",    ex_pc, m.pc);
      check_val("rnd_op",    {28'd0, ex_alu_op}, {28'd0, m.op});
      check_val("rnd_ctrl",  {28'd0, ex_valid, ex_reg_write, ex_mem_read, load_use_stall},
                             {28'd0, m.valid, m.rw, m.mr, lu});
      check_val("rnd_rd",    {27'd0, ex_rd_addr}, {27'd0, m.rd});
   endtask

   // ---------------- stimulus ----------------------------------------------
   initial begin
      clear_inputs();
      rst = 1'b1;
      #3;
      check_val("rst_valid", {31'd0, ex_valid}, 32'd0);
      check_val("rst_A", ex_A, 32'd0);
      check_val("rst_B", ex_B, 32'd0);
      check_val("rst_pc", ex_pc, 32'd0);
      check_val("rst_op", {28'd0, ex_alu_op}, 32'd0);
      check_val("rst_lus", {31'd0, load_use_stall}, 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // Plain load, one-cycle latency
      id_valid = 1'b1; id_rs1_addr = 5'd1; id_rs1_data = 32'd5; id_imm = 32'd7;
      id_b_sel = 1'b1; id_alu_op = 4'b0000; id_reg_write = 1'b1; id_pc = 32'h100;
      step();
      check_val("load_A", ex_A, 32'd5);
      check_val("load_B", ex_B, 32'd7);
      check_val("load_valid", {31'd0, ex_valid}, 32'd1);
      check_val("load_rw", {31'd0, ex_reg_write}, 32'd1);

      // Double forward, MEM beats WB
      clear_inputs();
      id_valid = 1'b1; id_rs1_addr = 5'd3; id_rs1_data = 32'h11;
      step();
      clear_inputs();
      mem_rd_addr = 5'd3; mem_result = 32'hAA; mem_reg_write = 1'b1;
      wb_rd_addr = 5'd3; wb_result = 32'hBB; wb_reg_write = 1'b1;
      #1 check_val("fwd_mem", ex_A, 32'hAA);
      mem_reg_write = 1'b0;
      #1 check_val("fwd_wb", ex_A, 32'hBB);
      wb_reg_write = 1'b0;
      #1 check_val("fwd_none", ex_A, 32'h11);

      // x0 guard
      clear_inputs();
      id_valid = 1'b1; id_rs1_addr = 5'd0; id_rs1_data = 32'h55;
      step();
      clear_inputs();
      mem_rd_addr = 5'd0; mem_reg_write = 1'b1; mem_result = 32'hFFFF_FFFF;
      #1 check_val("x0_guard", ex_A, 32'd0);

      // Stall capture of a WB result retiring mid-stall
      clear_inputs();
      id_valid = 1'b1; id_rs2_addr = 5'd5; id_rs2_data = 32'h1; id_b_sel = 1'b0;
      step();
      stall = 1'b1; wb_rd_addr = 5'd5; wb_reg_write = 1'b1; wb_result = 32'h1234;
      id_rs2_data = 32'h9999;
      step();
      wb_reg_write = 1'b0; wb_result = 32'h0;
      step();
      stall = 1'b0;
      #1 check_val("stall_B", ex_B, 32'h1234);
      check_val("stall_store", ex_store_data, 32'h1234);

      // Load-use detection
      clear_inputs();
      id_valid = 1'b1; id_mem_read = 1'b1; id_reg_write = 1'b1; id_rd_addr = 5'd7;
      step();
      clear_inputs();
      id_valid = 1'b1; id_rs2_addr = 5'd7;
      #1 check_val("lu_hit", {31'd0, load_use_stall}, 32'd1);
      id_valid = 1'b0;
      #1 check_val("lu_idinv", {31'd0, load_use_stall}, 32'd0);
      clear_inputs();
      id_valid = 1'b1; id_mem_read = 1'b1; id_rd_addr = 5'd0;
      step();
      clear_inputs();
      id_valid = 1'b1; id_rs1_addr = 5'd0;
      #1 check_val("lu_x0", {31'd0, load_use_stall}, 32'd0);

      // Flush together with stall
      clear_inputs();
      id_valid = 1'b1; id_reg_write = 1'b1; id_rd_addr = 5'd9; id_alu_op = 4'd3;
      step();
      flush = 1'b1; stall = 1'b1;
      step();
      check_val("flush_valid", {31'd0, ex_valid}, 32'd0);
      check_val("flush_rw", {31'd0, ex_reg_write}, 32'd0);
      check_val("flush_rd", {27'd0, ex_rd_addr}, 32'd0);

      // Asynchronous reset mid-cycle, then a normal first load
      clear_inputs();
      id_valid = 1'b1; id_rs1_data = 32'h77; id_rs1_addr = 5'd4; id_reg_write = 1'b1;
      id_pc = 32'h40; id_alu_op = 4'd5;
      step();
      check_val("pre_rst_valid", {31'd0, ex_valid}, 32'd1);
      rst = 1'b1;
      #1;
      check_val("arst_valid", {31'd0, ex_valid}, 32'd0);
      check_val("arst_A", ex_A, 32'd0);
      check_val("arst_pc", ex_pc, 32'd0);
      check_val("arst_op", {28'd0, ex_alu_op}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      step();
      check_val("post_rst_valid", {31'd0, ex_valid}, 32'd1);
      check_val("post_rst_A", ex_A, 32'h77);

      // Randomized run against the model, starting from reset
      clear_inputs();
      rst = 1'b1;
      m = empty_rec();
      step();
      rst = 1'b0;
      for (int i = 0; i < 400; i++) begin
         rst           = ($urandom_range(0, 99) < 3);
         stall         = ($urandom_range(0, 99) < 25);
         flush         = ($urandom_range(0, 99) < 10);
         id_valid      = ($urandom_range(0, 99) < 80);
         id_pc         = $urandom;
         id_rs1_data   = $urandom;
         id_rs2_data   = $urandom;
         id_imm        = $urandom;
         id_rs1_addr   = 5'($urandom_range(0, 7));
         id_rs2_addr   = 5'($urandom_range(0, 7));
         id_rd_addr    = 5'($urandom_range(0, 7));
         id_alu_op     = 4'($urandom_range(0, 15));
         id_a_sel      = 1'($urandom_range(0, 1));
         id_b_sel      = 1'($urandom_range(0, 1));
         id_reg_write  = 1'($urandom_range(0, 1));
         id_mem_read   = 1'($urandom_range(0, 1));
         mem_rd_addr   = 5'($urandom_range(0, 7));
         wb_rd_addr    = 5'($urandom_range(0, 7));
         mem_reg_write = 1'($urandom_range(0, 1));
         wb_reg_write  = 1'($urandom_range(0, 1));
         mem_result    = $urandom;
         wb_result     = $urandom;
         if (rst) m = empty_rec();
         #1;
         check_model();
         @(posedge clk);
         model_clock();
         #1;
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
